// File: rtl/accum_seq_ctrl.sv
// Frame accumulator controller: sums NUM_OPS streamed operands through an
// external shared adder (y = a + (sel ? accum : b)) and returns sum + sticky carry.
module accum_seq_ctrl #(
    parameter int unsigned NUM_OPS = 4,
    parameter int unsigned DW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [DW-1:0] data_a,
    output logic [DW-1:0] data_b,
    output logic [DW-1:0] accum,
    output logic          sel,
    input  logic [DW:0]   y_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_sum,
    output logic          out_ovf,
    output logic          busy
);

    localparam int unsigned CW = $clog2(NUM_OPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state: the first operand is parked in b_q, every later one captures an add
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (in_valid) begin
                    if (cnt_q == '0) begin
                        b_d   = in_data;
                        cnt_d = CW'(1);
                    end else begin
                        acc_d = y_out[DW-1:0];
                        ovf_d = ovf_q | y_out[DW];
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(NUM_OPS - 1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: data_a passes in_data straight to the adder only while an add is pending
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_ovf   = 1'b0;
        data_a    = '0;
        data_b    = b_q;
        accum     = acc_q;
        sel       = 1'b0;
        busy      = (state_q != S_IDLE);
        unique case (state_q)
            S_RUN: begin
                in_ready = 1'b1;
                if (cnt_q != '0) begin
                    data_a = in_data;
                    sel    = (cnt_q != CW'(1));
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                out_sum   = acc_q;
                out_ovf   = ovf_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Self-checking bench for accum_seq_ctrl: scenario tasks drive frames and compare
// against a running-sum reference computed from the operand list.
module tb_accum_seq_ctrl;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_ready;
    logic [3:0] data_a, data_b, accum;
    logic       sel;
    logic [4:0] y_out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_sum;
    logic       out_ovf;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame stimulus and observations
    logic [3:0]  ops [N];
    int unsigned vmask = 0;
    int          vlen = 0;
    int          hold = 0;
    bit          busy_start = 1'b0;

    logic        obs_sel [N];
    logic [3:0]  obs_a [N];
    logic [3:0]  obs_b [N];
    logic [3:0]  obs_accin [N];
    logic [3:0]  obs_accout [N];
    int          obs_cyc;
    bit          obs_timeout, obs_vfirst, obs_inrdy, obs_stable, obs_idle;
    logic [3:0]  obs_sum;
    logic        obs_ovf;

    logic [3:0]  exp_acc [N];
    logic [3:0]  exp_sum;
    logic        exp_ovf;

    int          vpulses = 0;
    logic        prev_ov = 1'b0;

    always #5 clk = ~clk;

    // External shared adder
    assign y_out = 5'(data_a) + (sel ? 5'(accum) : 5'(data_b));

    accum_seq_ctrl #(.NUM_OPS(N), .DW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .accum     (accum),
        .sel       (sel),
        .y_out     (y_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // Continuous invariant and out_valid pulse counter
    always @(negedge clk) begin
        #4;
        if (rst_n) begin
            n_checks++;
            if (in_ready && out_valid) begin
                n_fail++;
                $display("FAIL ready_valid_excl: in_ready=%0b out_valid=%0b, required not both 1", in_ready, out_valid);
            end
            if (out_valid && !prev_ov) vpulses++;
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference: first operand seeds the sum, every later operand is one add
    task automatic compute_model();
        int run, raw;
        run = int'(ops[0]);
        exp_ovf = 1'b0;
        exp_acc[0] = 4'd0;
        for (int k = 1; k < N; k++) begin
            raw = run + int'(ops[k]);
            if (raw > 15) exp_ovf = 1'b1;
            run = raw % 16;
            exp_acc[k] = 4'(run);
        end
        exp_sum = 4'(run);
    endtask

    // Drives one full frame and records what the DUT showed; compares nothing
    task automatic run_frame();
        int  idx, cyc;
        bit  hs;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = busy_start;
        idx = 0;
        cyc = 0;
        obs_timeout = 1'b0;
        while (idx < N) begin
            if (cyc >= 64) begin
                obs_timeout = 1'b1;
                break;
            end
            in_valid = (cyc < vlen) ? vmask[cyc] : 1'b1;
            in_data  = in_valid ? ops[idx] : 4'($urandom);
            #1;
            hs = in_valid && in_ready;
            if (hs) begin
                obs_sel[idx]   = sel;
                obs_a[idx]     = data_a;
                obs_b[idx]     = data_b;
                obs_accin[idx] = accum;
            end
            @(posedge clk);
            #1;
            if (hs) begin
                obs_accout[idx] = accum;
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        obs_cyc = cyc;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        obs_vfirst = out_valid;
        obs_inrdy  = in_ready;
        obs_sum    = out_sum;
        obs_ovf    = out_ovf;
        obs_stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (!(out_valid && out_sum == obs_sum && out_ovf == obs_ovf)) obs_stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        #1;
        obs_idle = !busy && !out_valid && !in_ready && out_sum == 4'd0 && !out_ovf;
    endtask

    task automatic test_reset();
        logic [20:0] v;
        repeat (3) @(negedge clk);
        #1;
        v = {in_ready, out_valid, out_sum, out_ovf, busy, data_a, data_b, accum, sel};
        n_checks++;
        if (v !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%0b in_ready=%0b, required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_basic();
        int p0;
        ops = '{4'd3, 4'd5, 4'd2, 4'd1};
        vlen = 0; hold = 0; busy_start = 1'b0;
        p0 = vpulses;
        run_frame();
        compute_model();
        n_checks++;
        if (obs_timeout || obs_cyc != N) begin
            n_fail++;
            $display("FAIL basic_cycles: got %0d (timeout=%0b), required %0d", obs_cyc, obs_timeout, N);
        end
        n_checks++;
        if (obs_vfirst !== 1'b1 || obs_inrdy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: out_valid=%0b in_ready=%0b after last handshake, required 1 0", obs_vfirst, obs_inrdy);
        end
        n_checks++;
        if (obs_sel[0] !== 1'b0 || obs_a[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_first_drive: sel=%0b data_a=%0d, required 0 0", obs_sel[0], obs_a[0]);
        end
        for (int k = 1; k < N; k++) begin
            n_checks++;
            if (obs_sel[k] !== (k != 1) || obs_a[k] !== ops[k] || obs_b[k] !== ops[0]) begin
                n_fail++;
                $display("FAIL basic_drive[%0d]: sel=%0b a=%0d b=%0d, required %0b %0d %0d",
                         k, obs_sel[k], obs_a[k], obs_b[k], (k != 1), ops[k], ops[0]);
            end
            n_checks++;
            if (obs_accin[k] !== exp_acc[k-1] || obs_accout[k] !== exp_acc[k]) begin
                n_fail++;
                $display("FAIL basic_acc[%0d]: in=%0d out=%0d, required %0d %0d",
                         k, obs_accin[k], obs_accout[k], exp_acc[k-1], exp_acc[k]);
            end
        end
        n_checks++;
        if (obs_sum !== 4'd11 || obs_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: sum=%0d ovf=%0b, required 11 0", obs_sum, obs_ovf);
        end
        n_checks++;
        if (!obs_idle || vpulses - p0 != 1) begin
            n_fail++;
            $display("FAIL basic_return: idle=%0b pulses=%0d, required 1 1", obs_idle, vpulses - p0);
        end
    endtask

    task automatic test_overflow();
        ops = '{4'd15, 4'd15, 4'd15, 4'd15};
        vlen = 0; hold = 0; busy_start = 1'b0;
        run_frame();
        compute_model();
        for (int k = 1; k < N; k++) begin
            n_checks++;
            if (obs_accout[k] !== exp_acc[k]) begin
                n_fail++;
                $display("FAIL ovf_acc[%0d]: got %0d, required %0d", k, obs_accout[k], exp_acc[k]);
            end
        end
        n_checks++;
        if (obs_sum !== 4'd12 || obs_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_result: sum=%0d ovf=%0b, required 12 1", obs_sum, obs_ovf);
        end
    endtask

    task automatic test_flow_control();
        logic [3:0] vals [2];
        vals = '{4'd4, 4'd3};
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) ops[k] = vals[r];
            vmask = 32'h69; vlen = 7; hold = 3; busy_start = 1'b0;
            run_frame();
            compute_model();
            n_checks++;
            if (obs_cyc != 7) begin
                n_fail++;
                $display("FAIL flow_cycles[%0d]: got %0d, required 7", r, obs_cyc);
            end
            n_checks++;
            if (obs_sum !== exp_sum || obs_ovf !== exp_ovf) begin
                n_fail++;
                $display("FAIL flow_result[%0d]: sum=%0d ovf=%0b, required %0d %0b", r, obs_sum, obs_ovf, exp_sum, exp_ovf);
            end
            n_checks++;
            if (!obs_stable || !obs_idle) begin
                n_fail++;
                $display("FAIL flow_hold[%0d]: stable=%0b idle_after=%0b, required 1 1", r, obs_stable, obs_idle);
            end
        end
        vlen = 0;
    endtask

    task automatic test_start_busy();
        int p0;
        for (int k = 0; k < N; k++) ops[k] = 4'($urandom);
        vlen = 0; hold = 2; busy_start = 1'b1;
        p0 = vpulses;
        run_frame();
        busy_start = 1'b0;
        compute_model();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (obs_sum !== exp_sum || obs_ovf !== exp_ovf || obs_cyc != N) begin
            n_fail++;
            $display("FAIL busy_result: sum=%0d ovf=%0b cyc=%0d, required %0d %0b %0d", obs_sum, obs_ovf, obs_cyc, exp_sum, exp_ovf, N);
        end
        n_checks++;
        if (vpulses - p0 != 1 || busy !== 1'b0 || !obs_idle) begin
            n_fail++;
            $display("FAIL busy_single: pulses=%0d busy=%0b idle=%0b, required 1 0 1", vpulses - p0, busy, obs_idle);
        end
    endtask

    task automatic test_abort();
        int p0;
        p0 = vpulses;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 4'd7;
        @(posedge clk);
        @(negedge clk);
        in_data = 4'd9;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        in_data = 4'd5;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%0b in_ready=%0b out_valid=%0b sum=%0d, required 0 0 0 0", busy, in_ready, out_valid, out_sum);
        end
        // abort wins over a same-cycle start in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || vpulses != p0) begin
            n_fail++;
            $display("FAIL abort_priority: busy=%0b pulses=%0d, required 0 0", busy, vpulses - p0);
        end
        ops = '{4'd1, 4'd1, 4'd1, 4'd1};
        vlen = 0; hold = 0; busy_start = 1'b0;
        run_frame();
        n_checks++;
        if (obs_sum !== 4'd4 || obs_ovf !== 1'b0 || obs_accin[1] !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_next: sum=%0d ovf=%0b acc_in=%0d, required 4 0 0", obs_sum, obs_ovf, obs_accin[1]);
        end
        n_checks++;
        if (vpulses - p0 != 1) begin
            n_fail++;
            $display("FAIL abort_pulses: got %0d, required 1", vpulses - p0);
        end
    endtask

    task automatic test_async_reset();
        logic [20:0] v;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 4'd9;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (busy !== 1'b1 || data_b !== 4'd9) begin
            n_fail++;
            $display("FAIL rst_pre: busy=%0b data_b=%0d, required 1 9", busy, data_b);
        end
        #1;
        rst_n = 1'b0;
        #1;
        v = {in_ready, out_valid, out_sum, out_ovf, busy, data_a, data_b, accum, sel};
        n_checks++;
        if (v !== 21'd0) begin
            n_fail++;
            $display("FAIL rst_async: got %h, required 0", v);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        ops = '{4'd2, 4'd2, 4'd2, 4'd2};
        vlen = 0; hold = 1; busy_start = 1'b0;
        run_frame();
        n_checks++;
        if (obs_sum !== 4'd8 || obs_ovf !== 1'b0 || obs_cyc != N) begin
            n_fail++;
            $display("FAIL rst_next: sum=%0d ovf=%0b cyc=%0d, required 8 0 %0d", obs_sum, obs_ovf, obs_cyc, N);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < N; k++) ops[k] = 4'($urandom);
            vmask = $urandom;
            vlen = 8;
            hold = $urandom_range(0, 3);
            busy_start = 1'b0;
            run_frame();
            compute_model();
            n_checks++;
            if (obs_timeout || obs_sum !== exp_sum || obs_ovf !== exp_ovf || !obs_vfirst) begin
                n_fail++;
                $display("FAIL rand_result[%0d]: sum=%0d ovf=%0b valid=%0b, required %0d %0b 1", f, obs_sum, obs_ovf, obs_vfirst, exp_sum, exp_ovf);
            end
            for (int k = 1; k < N; k++) begin
                n_checks++;
                if (obs_accout[k] !== exp_acc[k] || obs_sel[k] !== (k != 1)) begin
                    n_fail++;
                    $display("FAIL rand_step[%0d.%0d]: acc=%0d sel=%0b, required %0d %0b", f, k, obs_accout[k], obs_sel[k], exp_acc[k], (k != 1));
                end
            end
            n_checks++;
            if (!obs_stable || !obs_idle) begin
                n_fail++;
                $display("FAIL rand_hold[%0d]: stable=%0b idle=%0b, required 1 1", f, obs_stable, obs_idle);
            end
        end
        vlen = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_flow_control();
        test_start_busy();
        test_abort();
        test_async_reset();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
